trace_capture_ram: RTL and testbench
====================================

Name: trace_capture_ram

Overview:
- Single-clock circular capture buffer for the on-chip debug path.
- Successor to the plain dual-port sample RAM. Adds arm/trigger control, a programmable post-trigger depth and wrap-around history.
- Read-out is registered and addresses are logical, so the host always reads samples oldest-first.
- Sits between the probe mux, which supplies Data/Sample/Trigger, and the host read-out logic.

Parameters:
- adrbits, 12, log2 of buffer depth; depth D = 1<<adrbits.
- databits, 16, width of one captured sample.

Ports:
- Clock  input  1  sole clock; all state changes on its rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Data  input  databits  sample word.
- Sample  input  1  qualifies Data this cycle (sampling clock enable).
- Trigger  input  1  trigger condition; only acted on when Sample=1.
- Arm  input  1  one-cycle request to start a new capture.
- PostCount  input  adrbits  samples to store after the trigger sample; latched at trigger.
- RdAddress  input  adrbits  logical read index; 0 = oldest stored sample.
- RdEn  input  1  read strobe.
- Q  output  databits  read data, registered.
- Armed  output  1  high in PRE or POST.
- Triggered  output  1  high in POST or DONE.
- Done  output  1  high in DONE.
- Count  output  adrbits+1  number of valid stored samples, 0..D.
- TrigIndex  output  adrbits  logical index of the trigger sample.

Behaviour:
- Clock/reset: one clock, Clock. Reset is asynchronous and active-high.
- Reset values:
  - state=IDLE; WrPtr=0; Wrapped=0; Remain=0; TrigAddr=0.
  - Q=0; Armed=Triggered=Done=0; Count=0; TrigIndex=0.
  - Memory contents are not cleared.
- States: IDLE, PRE, POST, DONE.
- IDLE/DONE:
  - No writes.
  - Arm=1 -> PRE next cycle, with WrPtr=0 and Wrapped=0.
  - Trigger is ignored, including in the same cycle as Arm.
- PRE/POST: Arm is ignored.
- Write rule, PRE/POST with Sample=1:
  - mem[WrPtr]<=Data.
  - WrPtr<=WrPtr+1 mod D.
  - When WrPtr wraps D-1 -> 0, Wrapped<=1 (sticky until next Arm).
- Sample=0 means no write and no pointer or counter change.
- PRE, Sample=1, Trigger=1:
  - The trigger sample is written.
  - TrigAddr<=WrPtr; Remain<=PostCount.
  - Next state is DONE if PostCount==0, else POST.
- POST, Sample=1:
  - Sample is written; Remain decrements.
  - When Remain==1, the write completes and the block enters DONE.
  - Exactly PostCount samples follow the trigger sample.
  - Trigger is ignored in POST.
- PostCount max is D-1 (set by its width), so the trigger sample is never overwritten.
- Base = Wrapped ? WrPtr : 0.
- Count = Wrapped ? D : WrPtr. Combinational from registers; valid in every state.
- TrigIndex = (TrigAddr - Base) mod D. Meaningful once Triggered=1.
- Read path:
  - RdEn=1 at edge n -> Q = mem[(Base + RdAddress) mod D] after edge n (1-cycle latency).
  - RdEn=0 -> Q holds.
  - A read and a write to the same physical address in the same cycle returns the old data.
  - Reads are legal in any state; content is only guaranteed coherent in DONE.
- Reads with RdAddress >= Count return stale memory; no error flag.
- Reset mid-capture: immediate return to IDLE with all outputs at reset values. A following Arm starts a clean capture.

Test Plan:
- adrbits=4, databits=8 for all scenarios.
- 1. Reset held, then released:
  - Q=0, Armed=Triggered=Done=0, Count=0.
  - Arm during reset has no effect.
- 2. Basic trigger: Arm, then Sample=1 with Data=0..9, Trigger with Data=5, PostCount=3.
  - Done=1 after the Data=8 write; Data=9 is not stored.
  - Count=9, TrigIndex=5.
  - RdEn with RdAddress=0..8 gives Q=0..8, each one cycle after its strobe.
- 3. Wrap-around: Arm, Data=0..39, Trigger at Data=30, PostCount=4.
  - Done after the Data=34 write; Count=16; TrigIndex=11.
  - RdAddress=0 -> Q=19; RdAddress=15 -> Q=34.
- 4. Zero post-trigger: PostCount=0, Trigger at Data=2.
  - Done in the cycle after the trigger write.
  - Count=3, TrigIndex=2, Triggered=1.
- 5. Sample gating: alternate Sample=1/0 with Data incrementing every cycle; raise Trigger once while Sample=0.
  - Only Sample=1 words are stored, contiguously.
  - The Trigger with Sample=0 is ignored: Armed=1, Triggered=0.
  - A later Trigger with Sample=1 and PostCount=1 -> Done after one more sample.
- 6. Reset mid-POST: assert Reset mid-POST.
  - All outputs go to reset values asynchronously, without waiting for a Clock edge.
  - Re-Arm with Data=0..3, Trigger at 1, PostCount=2 -> Count=4, TrigIndex=1.

Source files
------------

// File: rtl/trace_capture_ram.sv
// trace_capture_ram: single-clock circular capture buffer with arm/trigger
// control, programmable post-trigger depth and oldest-first logical read-out.
module trace_capture_ram #(
    parameter int adrbits  = 12,
    parameter int databits = 16
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic [databits-1:0] Data,
    input  logic                Sample,
    input  logic                Trigger,
    input  logic                Arm,
    input  logic [adrbits-1:0]  PostCount,
    input  logic [adrbits-1:0]  RdAddress,
    input  logic                RdEn,
    output logic [databits-1:0] Q,
    output logic                Armed,
    output logic                Triggered,
    output logic                Done,
    output logic [adrbits:0]    Count,
    output logic [adrbits-1:0]  TrigIndex
);

    localparam int Depth = 1 << adrbits;

    typedef enum logic [1:0] {IDLE, PRE, POST, DONE} state_t;

    state_t              state;
    logic [adrbits-1:0]  WrPtr;
    logic                Wrapped;
    logic [adrbits-1:0]  Remain;
    logic [adrbits-1:0]  TrigAddr;
    logic [adrbits-1:0]  base;
    logic [adrbits-1:0]  rdaddr;
    logic                wr;
    logic [databits-1:0] mem [0:Depth-1];

    assign wr     = ((state == PRE) || (state == POST)) && Sample;
    assign base   = Wrapped ? WrPtr : '0;
    assign rdaddr = base + RdAddress;

    // Occupancy and trigger position, derived from the pointer registers
    always_comb begin
        Count     = Wrapped ? {1'b1, {adrbits{1'b0}}} : {1'b0, WrPtr};
        TrigIndex = TrigAddr - base;
    end

    // Capture control FSM with registered status flags
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            WrPtr     <= '0;
            Wrapped   <= 1'b0;
            Remain    <= '0;
            TrigAddr  <= '0;
            Armed     <= 1'b0;
            Triggered <= 1'b0;
            Done      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (Arm) begin
                        state     <= PRE;
                        WrPtr     <= '0;
                        Wrapped   <= 1'b0;
                        Armed     <= 1'b1;
                        Triggered <= 1'b0;
                        Done      <= 1'b0;
                    end
                end
                PRE: begin
                    if (Sample) begin
                        WrPtr <= WrPtr + 1'b1;
                        if (WrPtr == '1) Wrapped <= 1'b1;
                        if (Trigger) begin
                            TrigAddr  <= WrPtr;
                            Remain    <= PostCount;
                            Triggered <= 1'b1;
                            if (PostCount == '0) begin
                                state <= DONE;
                                Armed <= 1'b0;
                                Done  <= 1'b1;
                            end else begin
                                state <= POST;
                            end
                        end
                    end
                end
                POST: begin
                    if (Sample) begin
                        WrPtr  <= WrPtr + 1'b1;
                        Remain <= Remain - 1'b1;
                        if (WrPtr == '1) Wrapped <= 1'b1;
                        if (Remain == 1) begin
                            state <= DONE;
                            Armed <= 1'b0;
                            Done  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sample storage; contents survive reset
    always_ff @(posedge Clock) begin
        if (wr) mem[WrPtr] <= Data;
    end

    // Registered logical read port; same-cycle write returns the old word
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) Q <= '0;
        else if (RdEn) Q <= mem[rdaddr];
    end

endmodule

// File: tb/tb_trace_capture_ram.sv
// tb_trace_capture_ram: randomized and directed bench with a sample-history
// reference model for trace_capture_ram (adrbits=4, databits=8).
module tb_trace_capture_ram;

    logic       Clock = 1'b0;
    logic       Reset, Sample, Trigger, Arm, RdEn;
    logic [7:0] Data, Q;
    logic [3:0] PostCount, RdAddress, TrigIndex;
    logic       Armed, Triggered, Done;
    logic [4:0] Count;

    trace_capture_ram #(.adrbits(4), .databits(8)) dut (
        .Clock(Clock), .Reset(Reset), .Data(Data), .Sample(Sample),
        .Trigger(Trigger), .Arm(Arm), .PostCount(PostCount),
        .RdAddress(RdAddress), .RdEn(RdEn), .Q(Q), .Armed(Armed),
        .Triggered(Triggered), .Done(Done), .Count(Count), .TrigIndex(TrigIndex)
    );

    always #5 Clock = ~Clock;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: history of stored samples (oldest first, at most 16),
    // total samples written since Arm, and the sample number of the trigger.
    localparam int PH_IDLE = 0, PH_PRE = 1, PH_POST = 2, PH_DONE = 3;
    byte unsigned hist[$];
    int  phase, m_total, m_trig, m_remain;
    bit  ti_known, q_known;
    int  exp_q;
    bit  started = 1'b0;

    always @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            phase = PH_IDLE; m_total = 0; m_trig = 0; m_remain = 0;
            ti_known = 1'b1; q_known = 1'b1; exp_q = 0;
            hist.delete();
        end else begin
            if (RdEn) begin
                if (int'(RdAddress) < hist.size()) begin
                    exp_q = int'(hist[RdAddress]); q_known = 1'b1;
                end else begin
                    q_known = 1'b0;
                end
            end
            case (phase)
                PH_IDLE, PH_DONE: if (Arm) begin
                    phase = PH_PRE; m_total = 0; ti_known = 1'b0; hist.delete();
                end
                PH_PRE: if (Sample) begin
                    hist.push_back(Data); m_total++;
                    if (Trigger) begin
                        m_trig = m_total - 1; m_remain = int'(PostCount); ti_known = 1'b1;
                        phase = (PostCount == 0) ? PH_DONE : PH_POST;
                    end
                end
                PH_POST: if (Sample) begin
                    hist.push_back(Data); m_total++; m_remain--;
                    if (m_remain == 0) phase = PH_DONE;
                end
                default: ;
            endcase
            if (hist.size() > 16) void'(hist.pop_front());
        end
    end

    // Per-cycle comparison of every meaningful output against the model
    always @(negedge Clock) begin
        if (started && !Reset) begin
            int cnt, oldest;
            cnt    = (m_total >= 16) ? 16 : m_total;
            oldest = m_total - cnt;
            chk("Armed", int'(Armed), int'(phase == PH_PRE || phase == PH_POST));
            chk("Triggered", int'(Triggered), int'(phase == PH_POST || phase == PH_DONE));
            chk("Done", int'(Done), int'(phase == PH_DONE));
            chk("Count", int'(Count), cnt);
            if (ti_known) chk("TrigIndex", int'(TrigIndex), (m_trig - oldest) & 15);
            if (q_known) chk("Q", int'(Q), exp_q);
        end
    end

    task automatic drive(input logic a, input logic s, input logic t, input logic [7:0] d,
                         input logic [3:0] pc, input logic re, input logic [3:0] ra);
        Arm = a; Sample = s; Trigger = t; Data = d; PostCount = pc; RdEn = re; RdAddress = ra;
        @(negedge Clock);
    endtask

    task automatic idle();
        drive(0, 0, 0, 8'h00, 4'd0, 0, 4'd0);
    endtask

    task automatic rd_lit(input string name, input logic [3:0] ra, input int exp);
        drive(0, 0, 0, 8'h00, 4'd0, 1, ra);
        chk(name, int'(Q), exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // 1. Reset held with Arm asserted
        Reset = 1'b1; Arm = 1'b1; Sample = 0; Trigger = 0; Data = '0;
        PostCount = '0; RdEn = 0; RdAddress = '0;
        repeat (3) @(negedge Clock);
        chk("rst_Armed", int'(Armed), 0);
        chk("rst_Count", int'(Count), 0);
        chk("rst_Q", int'(Q), 0);
        Arm = 1'b0; Reset = 1'b0; started = 1'b1;
        idle();
        chk("rst_after_Armed", int'(Armed), 0);
        chk("rst_after_Done", int'(Done), 0);

        // 2. Basic trigger
        drive(1, 0, 0, 8'h00, 4'd0, 0, 4'd0);
        for (int i = 0; i < 10; i++) begin
            drive(0, 1, (i == 5), 8'(i), 4'd3, 0, 4'd0);
            if (i == 8) chk("basic_done_at_8", int'(Done), 1);
        end
        chk("basic_Count", int'(Count), 9);
        chk("basic_TrigIndex", int'(TrigIndex), 5);
        for (int i = 0; i < 9; i++) rd_lit("basic_read", 4'(i), i);

        // 3. Wrap-around
        drive(1, 0, 0, 8'h00, 4'd0, 0, 4'd0);
        for (int i = 0; i < 40; i++) begin
            drive(0, 1, (i == 30), 8'(i), 4'd4, 0, 4'd0);
            if (i == 33) chk("wrap_not_done_33", int'(Done), 0);
            if (i == 34) chk("wrap_done_34", int'(Done), 1);
        end
        chk("wrap_Count", int'(Count), 16);
        chk("wrap_TrigIndex", int'(TrigIndex), 11);
        rd_lit("wrap_read0", 4'd0, 19);
        rd_lit("wrap_read15", 4'd15, 34);

        // 4. Zero post-trigger; Trigger together with Arm is ignored
        drive(1, 1, 1, 8'hAA, 4'd0, 0, 4'd0);
        for (int i = 0; i < 3; i++) drive(0, 1, (i == 2), 8'(i), 4'd0, 0, 4'd0);
        chk("zero_Done", int'(Done), 1);
        chk("zero_Triggered", int'(Triggered), 1);
        chk("zero_Count", int'(Count), 3);
        chk("zero_TrigIndex", int'(TrigIndex), 2);

        // 5. Sample gating
        drive(1, 0, 0, 8'h00, 4'd0, 0, 4'd0);
        for (int i = 0; i < 10; i++) drive(0, (i % 2 == 0), (i == 5), 8'(i), 4'd1, 0, 4'd0);
        chk("gate_Armed", int'(Armed), 1);
        chk("gate_Triggered", int'(Triggered), 0);
        drive(0, 1, 1, 8'd10, 4'd1, 0, 4'd0);
        drive(0, 0, 0, 8'd11, 4'd1, 0, 4'd0);
        chk("gate_not_done", int'(Done), 0);
        drive(0, 1, 0, 8'd12, 4'd1, 0, 4'd0);
        chk("gate_Done", int'(Done), 1);
        chk("gate_Count", int'(Count), 7);
        rd_lit("gate_read1", 4'd1, 2);
        rd_lit("gate_read6", 4'd6, 12);

        // 6. Reset mid-POST, checked between clock edges
        drive(1, 0, 0, 8'h00, 4'd0, 0, 4'd0);
        for (int i = 0; i < 3; i++) drive(0, 1, (i == 1), 8'(i + 1), 4'd5, (i == 2), 4'd1);
        chk("midpost_Armed", int'(Armed), 1);
        chk("midpost_Q", int'(Q), 2);
        Arm = 0; Sample = 0; Trigger = 0; RdEn = 0;
        #2 Reset = 1'b1;
        #1;
        chk("async_Armed", int'(Armed), 0);
        chk("async_Triggered", int'(Triggered), 0);
        chk("async_Count", int'(Count), 0);
        chk("async_TrigIndex", int'(TrigIndex), 0);
        chk("async_Q", int'(Q), 0);
        @(negedge Clock);
        Reset = 1'b0;
        idle();
        drive(1, 0, 0, 8'h00, 4'd0, 0, 4'd0);
        for (int i = 0; i < 4; i++) drive(0, 1, (i == 1), 8'(i), 4'd2, 0, 4'd0);
        chk("rearm_Done", int'(Done), 1);
        chk("rearm_Count", int'(Count), 4);
        chk("rearm_TrigIndex", int'(TrigIndex), 1);

        // Randomized traffic checked by the model every cycle
        for (int i = 0; i < 600; i++) begin
            drive(($urandom % 25) == 0, ($urandom % 4) != 0, ($urandom % 15) == 0,
                  8'($urandom), 4'($urandom), ($urandom % 2) == 1, 4'($urandom));
        end
        if (phase == PH_IDLE || phase == PH_DONE) drive(1, 0, 0, 8'h00, 4'd0, 0, 4'd0);
        begin
            int n;
            n = 0;
            while (!Done && n < 100) begin
                drive(0, 1, 1, 8'($urandom), 4'd3, 1, 4'($urandom));
                n++;
            end
            chk("rand_reaches_done", int'(Done), 1);
        end
        for (int i = 0; i < 16; i++) drive(0, 0, 0, 8'h00, 4'd0, 1, 4'(i));
        idle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
